ikaopll_pg: RTL and testbench

IKAOPLL_PG -- requirements
Module: ikaopll_pg

---
 rtl/ikaopll_pg_if.sv | 27 ++
 rtl/ikaopll_pg.sv | 125 ++++++++++++
 tb/tb_ikaopll_pg.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ikaopll_pg_if.sv
// Slot-serial bus between the operator sequencer and the phase generator.
// Carries the per-slot frequency controls in and the per-slot phase out.
// All fields are sampled/updated only on enabled EMUCLK edges.
interface ikaopll_pg_if;
   logic        i_phi1_NCEN_n;
   logic        i_CYCLE_00;
   logic [8:0]  i_FNUM;
   logic [2:0]  i_BLOCK;
   logic [3:0]  i_MUL;
   logic        i_PM;
   logic [2:0]  i_PMVAL;
   logic        i_PHASE_RST;
   logic [9:0]  o_PHASE;
   logic        o_CYCLE_00_Z;

   modport master (
      output i_phi1_NCEN_n, i_CYCLE_00, i_FNUM, i_BLOCK, i_MUL,
             i_PM, i_PMVAL, i_PHASE_RST,
      input  o_PHASE, o_CYCLE_00_Z
   );

   modport slave (
      input  i_phi1_NCEN_n, i_CYCLE_00, i_FNUM, i_BLOCK, i_MUL,
             i_PM, i_PMVAL, i_PHASE_RST,
      output o_PHASE, o_CYCLE_00_Z
   );
endinterface

// File: rtl/ikaopll_pg.sv
// Phase generator: 18-slot time-multiplexed 19-bit phase accumulators with vibrato.
// Latency: slot entered on enabled edge n appears on o_PHASE after edge n+2.
// No backpressure: one slot per enabled edge, state frozen while i_phi1_NCEN_n=1.
module ikaopll_pg (
   input  logic        i_EMUCLK,
   input  logic        i_RST,
   ikaopll_pg_if.slave pg
);

   logic cen;
   assign cen = ~pg.i_phi1_NCEN_n;

   // stage 1 registers
   logic [10:0] s1_fm;
   logic [2:0]  s1_block;
   logic [3:0]  s1_mul;
   logic        s1_prst;
   logic        s1_cyc;

   // stage 2 registers
   logic [15:0] s2_inc;
   logic [3:0]  s2_mul;
   logic        s2_prst;
   logic        s2_cyc;

   // phase ring: entry 17 is the head read in stage 3, entry 0 the tail written
   logic [18:0] ring [18];

   logic [2:0]  pm_mag;
   logic [2:0]  pm_delta;
   logic [10:0] fm_next;
   logic [15:0] inc_next;
   logic [3:0]  half_k;
   logic [18:0] step;
   logic [18:0] acc_new;

   // Vibrato: signed offset of 0, m/2 or m (m = top FNUM bits) applied to 2*FNUM
   always_comb begin
      pm_mag   = pg.i_FNUM[8:6];
      pm_delta = 3'd0;
      case (pg.i_PMVAL[1:0])
         2'd1, 2'd3: pm_delta = {1'b0, pm_mag[2:1]};
         2'd2:       pm_delta = pm_mag;
         default:    pm_delta = 3'd0;
      endcase
      if (!pg.i_PM)
         pm_delta = 3'd0;
      if (pg.i_PMVAL[2])
         fm_next = {1'b0, pg.i_FNUM, 1'b0} - {8'd0, pm_delta};
      else
         fm_next = {1'b0, pg.i_FNUM, 1'b0} + {8'd0, pm_delta};
   end

   // Octave shift; the two LSBs below the phase increment resolution are dropped
   assign inc_next = 16'(({7'd0, s1_fm} << s1_block) >> 2);

   // Multiplier: K/2 for every code except 0, where K=1 means a plain halving
   always_comb begin
      half_k = 4'd0;
      case (s2_mul)
         4'd0:  half_k = 4'd0;
         4'd1:  half_k = 4'd1;
         4'd2:  half_k = 4'd2;
         4'd3:  half_k = 4'd3;
         4'd4:  half_k = 4'd4;
         4'd5:  half_k = 4'd5;
         4'd6:  half_k = 4'd6;
         4'd7:  half_k = 4'd7;
         4'd8:  half_k = 4'd8;
         4'd9:  half_k = 4'd9;
         4'd10: half_k = 4'd10;
         4'd11: half_k = 4'd10;
         4'd12: half_k = 4'd12;
         4'd13: half_k = 4'd12;
         default: half_k = 4'd15;
      endcase
      if (s2_mul == 4'd0)
         step = {4'd0, s2_inc[15:1]};
      else
         step = 19'(s2_inc) * 19'(half_k);
      acc_new = s2_prst ? 19'd0 : ring[17] + step;
   end

   // Three-stage slot pipeline and output registers
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         s1_fm           <= '0;
         s1_block        <= '0;
         s1_mul          <= '0;
         s1_prst         <= 1'b0;
         s1_cyc          <= 1'b0;
         s2_inc          <= '0;
         s2_mul          <= '0;
         s2_prst         <= 1'b0;
         s2_cyc          <= 1'b0;
         pg.o_PHASE      <= '0;
         pg.o_CYCLE_00_Z <= 1'b0;
      end else if (cen) begin
         s1_fm           <= fm_next;
         s1_block        <= pg.i_BLOCK;
         s1_mul          <= pg.i_MUL;
         s1_prst         <= pg.i_PHASE_RST;
         s1_cyc          <= pg.i_CYCLE_00;
         s2_inc          <= inc_next;
         s2_mul          <= s1_mul;
         s2_prst         <= s1_prst;
         s2_cyc          <= s1_cyc;
         pg.o_PHASE      <= acc_new[18:9];
         pg.o_CYCLE_00_Z <= s2_cyc;
      end
   end

   // Accumulator ring rotates one slot per enabled edge
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         for (int i = 0; i < 18; i++)
            ring[i] <= '0;
      end else if (cen) begin
         ring[0] <= acc_new;
         for (int i = 1; i < 18; i++)
            ring[i] <= ring[i-1];
      end
   end

endmodule

// File: tb/tb_ikaopll_pg.sv
// Directed testbench for ikaopll_pg.
// Drives one slot per enabled edge and records each slot's output two edges later.
// Expected phases are hand-computed from step sizes and round counts.
module tb_ikaopll_pg;

   logic emuclk = 1'b0;
   logic rst;

   ikaopll_pg_if pg_bus ();

   ikaopll_pg dut (
      .i_EMUCLK (emuclk),
      .i_RST    (rst),
      .pg       (pg_bus.slave)
   );

   always #5 emuclk = ~emuclk;

   int n_run;
   int n_fail;
   int cur_slot;
   int p0, p1, p2;
   logic [9:0] ph_seen [18];
   logic       cz_seen [18];

   // One enabled edge presenting slot cur_slot; records the output of the slot entered two edges ago
   task automatic tick(input logic [8:0] fnum, input logic [2:0] blk, input logic [3:0] mul,
                       input logic pm, input logic [2:0] pmval, input logic prst);
      @(negedge emuclk);
      pg_bus.i_phi1_NCEN_n = 1'b0;
      pg_bus.i_CYCLE_00    = (cur_slot == 0);
      pg_bus.i_FNUM        = fnum;
      pg_bus.i_BLOCK       = blk;
      pg_bus.i_MUL         = mul;
      pg_bus.i_PM          = pm;
      pg_bus.i_PMVAL       = pmval;
      pg_bus.i_PHASE_RST   = prst;
      @(posedge emuclk);
      #1;
      pg_bus.i_phi1_NCEN_n = 1'b1;
      p2 = p1;
      p1 = p0;
      p0 = cur_slot;
      if (p2 >= 0) begin
         ph_seen[p2] = pg_bus.o_PHASE;
         cz_seen[p2] = pg_bus.o_CYCLE_00_Z;
      end
      cur_slot = (cur_slot == 17) ? 0 : cur_slot + 1;
   endtask

   task automatic run_round(input logic [8:0] fnum, input logic [2:0] blk, input logic [3:0] mul,
                            input logic pm, input logic [2:0] pmval);
      for (int s = 0; s < 18; s++)
         tick(fnum, blk, mul, pm, pmval, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge emuclk);
      rst = 1'b1;
      repeat (2) @(negedge emuclk);
      rst = 1'b0;
      cur_slot = 0;
      p0 = -1;
      p1 = -1;
      p2 = -1;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (3) @(negedge emuclk);
      n_run++;
      if (pg_bus.o_PHASE !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_phase: got %0d want 0", pg_bus.o_PHASE);
      end
      n_run++;
      if (pg_bus.o_CYCLE_00_Z !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cyc: got %b want 0", pg_bus.o_CYCLE_00_Z);
      end
   endtask

   // step 2048 per round: phase advances by 4 per round and wraps at round 256
   task automatic test_wrap();
      do_reset();
      run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      n_run++;
      if (ph_seen[0] !== 10'd4) begin
         n_fail++;
         $display("FAIL wrap_r1_s0: got %0d want 4", ph_seen[0]);
      end
      n_run++;
      if (cz_seen[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL cyc_s0: got %b want 1", cz_seen[0]);
      end
      n_run++;
      if (cz_seen[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL cyc_s1: got %b want 0", cz_seen[1]);
      end
      run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      n_run++;
      if (ph_seen[3] !== 10'd8) begin
         n_fail++;
         $display("FAIL wrap_r2_s3: got %0d want 8", ph_seen[3]);
      end
      // clocks without enable must not move anything, even with hostile inputs
      pg_bus.i_FNUM      = 9'd511;
      pg_bus.i_PHASE_RST = 1'b1;
      pg_bus.i_CYCLE_00  = 1'b1;
      repeat (3) @(negedge emuclk);
      n_run++;
      if (pg_bus.o_PHASE !== 10'd8) begin
         n_fail++;
         $display("FAIL hold_phase: got %0d want 8", pg_bus.o_PHASE);
      end
      n_run++;
      if (pg_bus.o_CYCLE_00_Z !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_cyc: got %b want 0", pg_bus.o_CYCLE_00_Z);
      end
      for (int r = 3; r <= 255; r++)
         run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      n_run++;
      if (ph_seen[0] !== 10'd1020) begin
         n_fail++;
         $display("FAIL wrap_r255_s0: got %0d want 1020", ph_seen[0]);
      end
      run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      n_run++;
      if (ph_seen[0] !== 10'd0) begin
         n_fail++;
         $display("FAIL wrap_r256_s0: got %0d want 0", ph_seen[0]);
      end
      n_run++;
      if (ph_seen[10] !== 10'd0) begin
         n_fail++;
         $display("FAIL wrap_r256_s10: got %0d want 0", ph_seen[10]);
      end
   endtask

   // After 512 rounds o_PHASE equals step mod 1024; per-slot PMVAL/MUL changes each round
   task automatic test_vibrato();
      logic [8:0] fn   [8] = '{9'd448, 9'd448, 9'd448, 9'd448, 9'd448, 9'd448, 9'd448, 9'd100};
      logic [2:0] bk   [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
      logic [3:0] ml   [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd15, 4'd1, 4'd1};
      logic       pmen [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0] pv   [8] = '{3'd2, 3'd6, 3'd0, 3'd2, 3'd2, 3'd2, 3'd7, 3'd2};
      logic [9:0] exp_ph [8] = '{10'd225, 10'd222, 10'd224, 10'd224, 10'd112, 10'd303, 10'd223, 10'd400};
      do_reset();
      for (int r = 0; r < 512; r++) begin
         for (int s = 0; s < 18; s++) begin
            if (s < 8)
               tick(fn[s], bk[s], ml[s], pmen[s], pv[s], 1'b0);
            else
               tick(9'd0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b0);
         end
      end
      for (int s = 0; s < 8; s++) begin
         n_run++;
         if (ph_seen[s] !== exp_ph[s]) begin
            n_fail++;
            $display("FAIL vibrato_slot%0d: got %0d want %0d", s, ph_seen[s], exp_ph[s]);
         end
      end
   endtask

   // Largest step 493920: 964 after one round, 463552>>9 = 905 after two
   task automatic test_max();
      do_reset();
      for (int r = 1; r <= 2; r++) begin
         tick(9'd511, 3'd7, 4'd15, 1'b1, 3'd2, 1'b0);
         for (int s = 1; s < 18; s++)
            tick(9'd0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b0);
         n_run++;
         if (ph_seen[0] !== ((r == 1) ? 10'd964 : 10'd905)) begin
            n_fail++;
            $display("FAIL max_round%0d: got %0d want %0d", r, ph_seen[0], (r == 1) ? 964 : 905);
         end
      end
   endtask

   task automatic test_phase_rst();
      do_reset();
      run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      for (int s = 0; s < 18; s++)
         tick(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, (s == 5));
      n_run++;
      if (ph_seen[5] !== 10'd0) begin
         n_fail++;
         $display("FAIL prst_r3_s5: got %0d want 0", ph_seen[5]);
      end
      n_run++;
      if (ph_seen[4] !== 10'd12) begin
         n_fail++;
         $display("FAIL prst_r3_s4: got %0d want 12", ph_seen[4]);
      end
      n_run++;
      if (ph_seen[6] !== 10'd12) begin
         n_fail++;
         $display("FAIL prst_r3_s6: got %0d want 12", ph_seen[6]);
      end
      run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      n_run++;
      if (ph_seen[5] !== 10'd4) begin
         n_fail++;
         $display("FAIL prst_r4_s5: got %0d want 4", ph_seen[5]);
      end
      n_run++;
      if (ph_seen[6] !== 10'd16) begin
         n_fail++;
         $display("FAIL prst_r4_s6: got %0d want 16", ph_seen[6]);
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      run_round(9'd256, 3'd4, 4'd1, 1'b0, 3'd0);
      for (int s = 0; s < 3; s++)
         tick(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (pg_bus.o_PHASE !== 10'd8 || pg_bus.o_CYCLE_00_Z !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_rst: got phase %0d cyc %b want 8 1", pg_bus.o_PHASE, pg_bus.o_CYCLE_00_Z);
      end
      @(negedge emuclk);
      #2;
      rst = 1'b1;
      #1;
      n_run++;
      if (pg_bus.o_PHASE !== 10'd0) begin
         n_fail++;
         $display("FAIL midrst_phase: got %0d want 0", pg_bus.o_PHASE);
      end
      n_run++;
      if (pg_bus.o_CYCLE_00_Z !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_cyc: got %b want 0", pg_bus.o_CYCLE_00_Z);
      end
      @(negedge emuclk);
      rst = 1'b0;
      cur_slot = 7;
      p0 = -1;
      p1 = -1;
      p2 = -1;
      for (int s = 7; s < 18; s++)
         tick(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 1'b0);
      tick(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 1'b0);
      tick(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (pg_bus.o_CYCLE_00_Z !== 1'b0) begin
         n_fail++;
         $display("FAIL rerun_cyc_early: got %b want 0", pg_bus.o_CYCLE_00_Z);
      end
      tick(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (pg_bus.o_CYCLE_00_Z !== 1'b1) begin
         n_fail++;
         $display("FAIL rerun_cyc: got %b want 1", pg_bus.o_CYCLE_00_Z);
      end
      n_run++;
      if (pg_bus.o_PHASE !== 10'd4) begin
         n_fail++;
         $display("FAIL rerun_phase: got %0d want 4", pg_bus.o_PHASE);
      end
   endtask

   initial begin
      n_run    = 0;
      n_fail   = 0;
      cur_slot = 0;
      p0 = -1;
      p1 = -1;
      p2 = -1;
      rst = 1'b1;
      pg_bus.i_phi1_NCEN_n = 1'b1;
      pg_bus.i_CYCLE_00    = 1'b0;
      pg_bus.i_FNUM        = 9'd0;
      pg_bus.i_BLOCK       = 3'd0;
      pg_bus.i_MUL         = 4'd0;
      pg_bus.i_PM          = 1'b0;
      pg_bus.i_PMVAL       = 3'd0;
      pg_bus.i_PHASE_RST   = 1'b0;
      for (int s = 0; s < 18; s++) begin
         ph_seen[s] = 10'd0;
         cz_seen[s] = 1'b0;
      end
      test_reset();
      test_wrap();
      test_vibrato();
      test_max();
      test_phase_rst();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
